// File: rtl/target_value_compute.sv
// TD target y = done ? r : r + GAMMA*maxQ, sequenced over one FP32 multiplier
// and one FP32 adder with valid-in/valid-out handshakes.
module tvc_fp_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid,
    output logic [31:0] res
);
    logic [47:0] p;
    logic [22:0] man;
    logic [23:0] mr;
    logic [9:0]  eu;
    logic [7:0]  ev;
    logic        g, s, rnd, sgn, az, bz, ai, bi;
    logic [31:0] r;

    always_comb begin
        sgn = a[31] ^ b[31];
        az  = a[30:23] == 8'h00;
        bz  = b[30:23] == 8'h00;
        ai  = a[30:23] == 8'hFF;
        bi  = b[30:23] == 8'hFF;
        p   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        if (p[47]) begin
            man = p[46:24]; g = p[23]; s = |p[22:0];
        end else begin
            man = p[45:23]; g = p[22]; s = |p[21:0];
        end
        rnd = g & (s | man[0]);
        mr  = {1'b0, man} + {23'd0, rnd};
        eu  = {2'b00, a[30:23]} + {2'b00, b[30:23]}
            + {9'd0, p[47]} + {9'd0, mr[23]};
        ev  = 8'(eu - 10'd127);
        // denormal inputs and underflowing results flush to signed zero
        if ((ai && a[22:0] != 0) || (bi && b[22:0] != 0)
            || (ai && bz) || (bi && az))
            r = 32'h7FC00000;
        else if (ai || bi || eu >= 10'd382)
            r = {sgn, 8'hFF, 23'd0};
        else if (az || bz || eu <= 10'd127)
            r = {sgn, 31'd0};
        else
            r = {sgn, ev, mr[22:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            res   <= 32'd0;
        end else begin
            valid <= start;
            if (start) res <= r;
        end
    end
endmodule

module tvc_fp_add (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid,
    output logic [31:0] res
);
    logic [31:0] x, y, r;
    logic [7:0]  ex, ey, d;
    logic [23:0] mx, my;
    logic [53:0] t;
    logic [26:0] al, bx, nm;
    logic [27:0] sm;
    logic [24:0] mr;
    logic [9:0]  eu, e2;
    logic [4:0]  lz;
    logic        rnd, uf;

    always_comb begin
        x  = (b[30:0] > a[30:0]) ? b : a;
        y  = (b[30:0] > a[30:0]) ? a : b;
        ex = x[30:23];
        ey = y[30:23];
        mx = (ex == 8'h00) ? 24'd0 : {1'b1, x[22:0]};
        my = (ey == 8'h00) ? 24'd0 : {1'b1, y[22:0]};
        d  = ex - ey;
        t  = {my, 30'd0} >> ((d > 8'd27) ? 8'd28 : d);
        al = {t[53:28], t[27] | (|t[26:0])};
        bx = {mx, 3'b000};
        if (x[31] == y[31]) sm = {1'b0, bx} + {1'b0, al};
        else                sm = {1'b0, bx} - {1'b0, al};
        lz = 5'd27;
        for (int i = 0; i < 27; i++)
            if (sm[i]) lz = 5'(26 - i);
        if (sm[27]) begin
            nm = {sm[27:2], sm[1] | sm[0]};
            eu = {2'b00, ex} + 10'd1;
            uf = 1'b0;
        end else begin
            nm = sm[26:0] << lz;
            eu = {2'b00, ex} - {5'd0, lz};
            uf = {3'b000, lz} >= ex;
        end
        rnd = nm[2] & (nm[1] | nm[0] | nm[3]);
        mr  = {1'b0, nm[26:3]} + {24'd0, rnd};
        e2  = eu + {9'd0, mr[24]};
        if (ex == 8'hFF)
            r = (x[22:0] != 0 || (ey == 8'hFF && x[31] != y[31]))
              ? 32'h7FC00000 : x;
        else if (sm == 28'd0 || uf)
            r = 32'd0;
        else if (e2 >= 10'd255)
            r = {x[31], 8'hFF, 23'd0};
        else
            r = {x[31], e2[7:0], mr[24] ? mr[23:1] : mr[22:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            res   <= 32'd0;
        end else begin
            valid <= start;
            if (start) res <= r;
        end
    end
endmodule

module target_value_compute #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] GAMMA      = 32'h3F666666
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_q_valid,
    input  logic [DATA_WIDTH-1:0] i_max_q,
    input  logic                  i_sample_valid,
    input  logic [DATA_WIDTH-1:0] i_reward,
    input  logic                  i_done,
    output logic [DATA_WIDTH-1:0] o_target,
    output logic                  o_valid,
    output logic                  o_busy
);
    typedef enum logic [2:0] {IDLE, MUL, ADD, OUT_D, OUT} state_t;
    state_t state;

    logic [DATA_WIDTH-1:0] max_q, reward, product, sum;
    logic [DATA_WIDTH-1:0] mul_res, add_res;
    logic have_q, have_s, done_r;
    logic mul_start, add_start, mul_valid, add_valid;
    logic cap_q, cap_s, hq, hs, dn;

    assign cap_q = i_q_valid & ~o_busy;
    assign cap_s = i_sample_valid & ~o_busy;
    assign hq    = have_q | cap_q;
    assign hs    = have_s | cap_s;
    assign dn    = cap_s ? i_done : done_r;

    tvc_fp_mul u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (GAMMA),
        .b     (max_q),
        .valid (mul_valid),
        .res   (mul_res)
    );

    tvc_fp_add u_add (
        .clk   (clk),
        .rst_n (rst_n),
        .start (add_start),
        .a     (reward),
        .b     (product),
        .valid (add_valid),
        .res   (add_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            o_target  <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            max_q     <= '0;
            reward    <= '0;
            product   <= '0;
            sum       <= '0;
            have_q    <= 1'b0;
            have_s    <= 1'b0;
            done_r    <= 1'b0;
            mul_start <= 1'b0;
            add_start <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            add_start <= 1'b0;
            o_valid   <= 1'b0;
            if (cap_q) begin
                max_q  <= i_max_q;
                have_q <= 1'b1;
            end
            if (cap_s) begin
                reward <= i_reward;
                done_r <= i_done;
                have_s <= 1'b1;
            end
            unique case (state)
                IDLE: if (hq && hs) begin
                    o_busy <= 1'b1;
                    if (dn) begin
                        state <= OUT_D;
                    end else begin
                        state     <= MUL;
                        mul_start <= 1'b1;
                    end
                end
                MUL: if (mul_valid) begin
                    product   <= mul_res;
                    add_start <= 1'b1;
                    state     <= ADD;
                end
                ADD: if (add_valid) begin
                    sum   <= add_res;
                    state <= OUT;
                end
                OUT_D, OUT: begin
                    o_target <= (state == OUT_D) ? reward : sum;
                    o_valid  <= 1'b1;
                    o_busy   <= 1'b0;
                    have_q   <= 1'b0;
                    have_s   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_target_value_compute.sv
// Directed bench for target_value_compute: GAMMA=0.5 instance for exact
// results, plus a default-GAMMA instance for the 0.9 case.
module tb_target_value_compute;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        q_valid = 1'b0;
    logic        sample_valid = 1'b0;
    logic        done = 1'b0;
    logic [31:0] max_q = 32'd0;
    logic [31:0] reward = 32'd0;
    logic [31:0] target, target9;
    logic        valid, busy, valid9, busy9;
    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int mcnt = 0;

    always #5 clk = ~clk;

    target_value_compute #(
        .DATA_WIDTH (32),
        .GAMMA      (32'h3F000000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_q_valid      (q_valid),
        .i_max_q        (max_q),
        .i_sample_valid (sample_valid),
        .i_reward       (reward),
        .i_done         (done),
        .o_target       (target),
        .o_valid        (valid),
        .o_busy         (busy)
    );

    target_value_compute dut9 (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_q_valid      (q_valid),
        .i_max_q        (max_q),
        .i_sample_valid (sample_valid),
        .i_reward       (reward),
        .i_done         (done),
        .o_target       (target9),
        .o_valid        (valid9),
        .o_busy         (busy9)
    );

    always @(posedge clk) begin
        #2;
        if (valid) vcnt++;
        if (dut.mul_start) mcnt++;
    end

    task automatic send(input bit q, input bit s, input logic [31:0] mq,
                        input logic [31:0] r, input bit d);
        @(negedge clk);
        q_valid = q;
        sample_valid = s;
        max_q = mq;
        reward = r;
        done = d;
        @(negedge clk);
        q_valid = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic wait_out(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (valid) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (target !== 32'd0) begin
            errors++;
            $display("FAIL reset_target got %h exp 00000000", target);
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b exp 0", valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", busy);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_same_cycle;
        int n0;
        bit seen;
        n0 = vcnt;
        send(1'b1, 1'b1, 32'h40000000, 32'h3F800000, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_busy got %b exp 1", busy);
        end
        wait_out(seen);
        checks++;
        if (!seen || target !== 32'h40000000) begin
            errors++;
            $display("FAIL t1_target seen %0d got %h exp 40000000",
                     seen, target);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (vcnt - n0 != 1) begin
            errors++;
            $display("FAIL t1_pulses got %0d exp 1", vcnt - n0);
        end
        checks++;
        if (target !== 32'h40000000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_hold got %h busy %b exp 40000000 busy 0",
                     target, busy);
        end
    endtask

    task automatic test_sample_first;
        int n0;
        bit seen;
        n0 = vcnt;
        send(1'b0, 1'b1, 32'h0, 32'h00000000, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (vcnt != n0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t2_early got pulses %0d busy %b exp 0 0",
                     vcnt - n0, busy);
        end
        send(1'b1, 1'b0, 32'h40800000, 32'hDEADBEEF, 1'b1);
        wait_out(seen);
        checks++;
        if (!seen || target !== 32'h40000000) begin
            errors++;
            $display("FAIL t2_target seen %0d got %h exp 40000000",
                     seen, target);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (vcnt - n0 != 1) begin
            errors++;
            $display("FAIL t2_pulses got %0d exp 1", vcnt - n0);
        end
    endtask

    task automatic test_done;
        int m0;
        m0 = mcnt;
        send(1'b1, 1'b1, 32'h42C80000, 32'hBF800000, 1'b1);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL t3_early got %b exp 0", valid);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || target !== 32'hBF800000) begin
            errors++;
            $display("FAIL t3_target valid %b got %h exp 1 BF800000",
                     valid, target);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL t3_width got %b exp 0", valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (mcnt != m0) begin
            errors++;
            $display("FAIL t3_mul_start got %0d exp 0", mcnt - m0);
        end
    endtask

    task automatic test_busy_ignore;
        int n0;
        bit seen;
        n0 = vcnt;
        send(1'b1, 1'b1, 32'h40000000, 32'hBF800000, 1'b0);
        send(1'b1, 1'b0, 32'h41200000, 32'h0, 1'b0);
        wait_out(seen);
        checks++;
        if (!seen || target !== 32'h00000000) begin
            errors++;
            $display("FAIL t4_target seen %0d got %h exp 00000000",
                     seen, target);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (vcnt - n0 != 1) begin
            errors++;
            $display("FAIL t4_pulses got %0d exp 1", vcnt - n0);
        end
        n0 = vcnt;
        send(1'b0, 1'b1, 32'h0, 32'h3F800000, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if (vcnt != n0) begin
            errors++;
            $display("FAIL t4_flag_clear got %0d exp 0", vcnt - n0);
        end
        send(1'b1, 1'b0, 32'h40400000, 32'h0, 1'b0);
        wait_out(seen);
        checks++;
        if (!seen || target !== 32'h3F800000) begin
            errors++;
            $display("FAIL t4_pair seen %0d got %h exp 3F800000",
                     seen, target);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n0;
        bit hit;
        bit seen;
        hit = 1'b0;
        send(1'b1, 1'b1, 32'h40000000, 32'h3F800000, 1'b0);
        for (int i = 0; i < 30 && !hit; i++) begin
            if (dut.add_start) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL t5_reach_add got 0 exp 1");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || target !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_reset got %b %h %b exp 0 00000000 0",
                     valid, target, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n0 = vcnt;
        repeat (8) @(negedge clk);
        checks++;
        if (vcnt != n0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_stale got pulses %0d busy %b exp 0 0",
                     vcnt - n0, busy);
        end
        send(1'b1, 1'b1, 32'h40000000, 32'h3F800000, 1'b0);
        wait_out(seen);
        checks++;
        if (!seen || target !== 32'h40000000) begin
            errors++;
            $display("FAIL t5_target seen %0d got %h exp 40000000",
                     seen, target);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (vcnt - n0 != 1) begin
            errors++;
            $display("FAIL t5_pulses got %0d exp 1", vcnt - n0);
        end
    endtask

    task automatic test_gamma09;
        bit seen;
        send(1'b1, 1'b1, 32'h41200000, 32'h3F800000, 1'b0);
        wait_out(seen);
        checks++;
        if (!seen || valid9 !== 1'b1 ||
            !(target9 == 32'h41200000 || target9 == 32'h411FFFFF ||
              target9 == 32'h41200001)) begin
            errors++;
            $display("FAIL t6_gamma09 valid %b got %h exp 41200000 +/-1",
                     valid9, target9);
        end
        checks++;
        if (!seen || target !== 32'h40C00000) begin
            errors++;
            $display("FAIL t6_gamma05 seen %0d got %h exp 40C00000",
                     seen, target);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_same_cycle;
        test_sample_first;
        test_done;
        test_busy_ignore;
        test_reset_mid;
        test_gamma09;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
